// File: rtl/regf_arbiter_pkg.sv
// rtl/regf_arbiter_pkg.sv - Shared widths, requester indices and FSM encodings for the regf arbiter
package regf_arbiter_pkg;

    localparam int ARB_DATA_W = 32;
    localparam int ARB_ADDR_W = 4;
    localparam int ARB_N_REQ  = 3;

    localparam int REQ_PAR  = 0;
    localparam int REQ_PS2  = 1;
    localparam int REQ_DISP = 2;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/regf_arb_pick.sv
// rtl/regf_arb_pick.sv - Combinational winner search starting at ptr over req with masked entries removed
module regf_arb_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [N_REQ-1:0] eligible;
    int               slot;

    assign eligible = req & ~mask;

    // Walk offsets from the far end so the last hit is the one closest to ptr;
    // a constant zero ptr degenerates to lowest-index-wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        slot  = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            slot = int'(ptr) + k;
            if (slot >= N_REQ) begin
                slot = slot - N_REQ;
            end
            if (eligible[slot]) begin
                idx   = IDX_W'(slot);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regf_arbiter.sv
// rtl/regf_arbiter.sv - Serialises requester accesses onto the single regf port; REGF_ARB_RR_EN selects round-robin
module regf_arbiter
    import regf_arbiter_pkg::*;
#(
    parameter int DATA_W      = ARB_DATA_W,
    parameter int REGF_ADDR_W = ARB_ADDR_W,
    parameter int N_REQ       = ARB_N_REQ
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0]             we,
    input  logic [N_REQ*REGF_ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0]      wdata,
    output logic [N_REQ-1:0]             gnt,
    output logic [DATA_W-1:0]            rdata,
    output logic                         busy,
    output logic                         regf_en,
    output logic                         regf_we,
    output logic [REGF_ADDR_W-1:0]       regf_addr,
    output logic [DATA_W-1:0]            regf_wdata,
    input  logic [DATA_W-1:0]            regf_rdata
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (idx == IDX_W'(i)) begin
                oh[i] = 1'b1;
            end
        end
        return oh;
    endfunction

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       cur_idx_q, cur_idx_d;
    logic [N_REQ-1:0]       gnt_q, gnt_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   regf_en_q, regf_en_d;
    logic                   regf_we_q, regf_we_d;
    logic [REGF_ADDR_W-1:0] regf_addr_q, regf_addr_d;
    logic [DATA_W-1:0]      regf_wdata_q, regf_wdata_d;

    logic [IDX_W-1:0]       rr_ptr;
    logic [N_REQ-1:0]       pick_mask;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic                   take;
    logic                   sel_we;
    logic [REGF_ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0]      sel_wdata;
    logic [DATA_W-1:0]      resp_data;

    // Only the requester just served is hidden, so a held req queues another
    // access instead of being served twice off one assertion.
    assign pick_mask = (state_q == ARB_RESP) ? idx_onehot(cur_idx_q) : '0;
    assign take      = pick_valid && ((state_q == ARB_IDLE) || (state_q == ARB_RESP));

    regf_arb_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .mask  (pick_mask),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

`ifdef REGF_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (take) begin
            rr_ptr_d = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rr_ptr = rr_ptr_q;
`else
    assign rr_ptr = '0;
`endif

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_we    = we[i];
                sel_addr  = addr[i*REGF_ADDR_W +: REGF_ADDR_W];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // regf_we/regf_wdata stay loaded through RESP and describe the access being answered.
    assign resp_data = regf_we_q ? regf_wdata_q : regf_rdata;

    always_comb begin
        state_d      = state_q;
        cur_idx_d    = cur_idx_q;
        gnt_d        = '0;
        rdata_d      = rdata_q;
        regf_en_d    = 1'b0;
        regf_we_d    = regf_we_q;
        regf_addr_d  = regf_addr_q;
        regf_wdata_d = regf_wdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (take) begin
                    state_d = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                gnt_d   = idx_onehot(cur_idx_q);
                state_d = ARB_RESP;
            end
            ARB_RESP: begin
                rdata_d = resp_data;
                state_d = take ? ARB_ACCESS : ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        if (take) begin
            cur_idx_d    = pick_idx;
            regf_en_d    = 1'b1;
            regf_we_d    = sel_we;
            regf_addr_d  = sel_addr;
            regf_wdata_d = sel_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            cur_idx_q    <= '0;
            gnt_q        <= '0;
            rdata_q      <= '0;
            regf_en_q    <= 1'b0;
            regf_we_q    <= 1'b0;
            regf_addr_q  <= '0;
            regf_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_idx_q    <= cur_idx_d;
            gnt_q        <= gnt_d;
            rdata_q      <= rdata_d;
            regf_en_q    <= regf_en_d;
            regf_we_q    <= regf_we_d;
            regf_addr_q  <= regf_addr_d;
            regf_wdata_q <= regf_wdata_d;
        end
    end

    // regf_rdata only arrives in the RESP cycle, so it is forwarded alongside gnt.
    assign rdata      = (state_q == ARB_RESP) ? resp_data : rdata_q;
    assign gnt        = gnt_q;
    assign busy       = (state_q != ARB_IDLE);
    assign regf_en    = regf_en_q;
    assign regf_we    = regf_we_q;
    assign regf_addr  = regf_addr_q;
    assign regf_wdata = regf_wdata_q;

endmodule

// File: tb/tb_regf_arbiter.sv
// tb/tb_regf_arbiter.sv - Directed self-checking bench for regf_arbiter with a behavioural regf model
module tb_regf_arbiter;
    import regf_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [11:0] addr;
    logic [95:0] wdata;
    logic [2:0]  gnt;
    logic [31:0] rdata;
    logic        busy;
    logic        regf_en;
    logic        regf_we;
    logic [3:0]  regf_addr;
    logic [31:0] regf_wdata;
    logic [31:0] regf_rdata;

    logic [31:0] mem [16];

    int n_tests;
    int n_fail;

    regf_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .gnt        (gnt),
        .rdata      (rdata),
        .busy       (busy),
        .regf_en    (regf_en),
        .regf_we    (regf_we),
        .regf_addr  (regf_addr),
        .regf_wdata (regf_wdata),
        .regf_rdata (regf_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (regf_en) begin
            if (regf_we) mem[regf_addr] <= regf_wdata;
            else         regf_rdata     <= mem[regf_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [3:0] a, input logic [31:0] d);
        req[i]           = 1'b1;
        we[i]            = w;
        addr[i*4 +: 4]   = a;
        wdata[i*32 +: 32] = d;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        req = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({gnt, busy, regf_en, regf_we} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: gnt=%b busy=%b en=%b we=%b want all 0", gnt, busy, regf_en, regf_we);
        end
        n_tests++;
        if (regf_addr !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_addr: got %h want 0", regf_addr);
        end
        n_tests++;
        if (regf_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_wdata: got %h want 0", regf_wdata);
        end
        n_tests++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h want 0", rdata);
        end
    endtask

    task automatic test_single_write();
        set_req(REQ_PAR, 1'b1, 4'd3, 32'hDEAD_BEEF);
        step();
        n_tests++;
        if ({regf_en, regf_we, regf_addr} !== {1'b1, 1'b1, 4'd3}) begin
            n_fail++;
            $display("FAIL write_access: en=%b we=%b addr=%h want 1 1 3", regf_en, regf_we, regf_addr);
        end
        n_tests++;
        if (regf_wdata !== 32'hDEAD_BEEF || gnt !== 3'b000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL write_access_data: wdata=%h gnt=%b busy=%b want deadbeef 000 1", regf_wdata, gnt, busy);
        end
        step();
        n_tests++;
        if (gnt !== 3'b001 || rdata !== 32'hDEAD_BEEF || regf_en !== 1'b0) begin
            n_fail++;
            $display("FAIL write_gnt: gnt=%b rdata=%h en=%b want 001 deadbeef 0", gnt, rdata, regf_en);
        end
        step();
        n_tests++;
        if (busy !== 1'b0 || gnt !== 3'b000) begin
            n_fail++;
            $display("FAIL write_done: busy=%b gnt=%b want 0 000", busy, gnt);
        end
        req = '0;
        step();
    endtask

    task automatic test_single_read();
        set_req(REQ_PS2, 1'b1, 4'd5, 32'h1234_5678);
        step();
        step();
        step();
        req = '0;
        step();
        set_req(REQ_PS2, 1'b0, 4'd5, 32'h0);
        step();
        n_tests++;
        if ({regf_en, regf_we, regf_addr} !== {1'b1, 1'b0, 4'd5}) begin
            n_fail++;
            $display("FAIL read_access: en=%b we=%b addr=%h want 1 0 5", regf_en, regf_we, regf_addr);
        end
        step();
        n_tests++;
        if (gnt !== 3'b010 || rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL read_gnt: gnt=%b rdata=%h want 010 12345678", gnt, rdata);
        end
        step();
        req = '0;
        n_tests++;
        if (rdata !== 32'h1234_5678 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL read_hold: rdata=%h busy=%b want 12345678 0", rdata, busy);
        end
        step();
    endtask

    task automatic test_contention();
        logic [2:0]  exp_gnt [9];
        logic        drop;
        logic [31:0] exp_last;
        apply_reset();
`ifdef REGF_ARB_RR_EN
        exp_gnt  = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b000};
        drop     = 1'b1;
        exp_last = 32'hDEAD_BEEF;
`else
        exp_gnt  = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b010};
        drop     = 1'b0;
        exp_last = 32'h2222_0000;
`endif
        set_req(REQ_PAR,  1'b1, 4'd8, 32'h1111_0000);
        set_req(REQ_PS2,  1'b1, 4'd9, 32'h2222_0000);
        set_req(REQ_DISP, 1'b0, 4'd3, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            step();
            n_tests++;
            if (gnt !== exp_gnt[c]) begin
                n_fail++;
                $display("FAIL contention_c%0d: gnt=%b want %b", c, gnt, exp_gnt[c]);
            end
            if (drop) begin
                for (int i = 0; i < 3; i++) begin
                    if (exp_gnt[c-1][i]) req[i] = 1'b0;
                end
            end
        end
        req = '0;
        step();
        n_tests++;
        if (rdata !== exp_last) begin
            n_fail++;
            $display("FAIL contention_rdata: got %h want %h", rdata, exp_last);
        end
        step();
        step();
        step();
    endtask

    task automatic test_masking();
        logic [2:0] exp_gnt [11];
        exp_gnt = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b100, 3'b000,
                    3'b001, 3'b000, 3'b100, 3'b000, 3'b001};
        apply_reset();
        set_req(REQ_PAR,  1'b0, 4'd3, 32'h0);
        set_req(REQ_DISP, 1'b0, 4'd9, 32'h0);
        for (int c = 1; c <= 10; c++) begin
            step();
            n_tests++;
            if (gnt !== exp_gnt[c]) begin
                n_fail++;
                $display("FAIL masking_c%0d: gnt=%b want %b", c, gnt, exp_gnt[c]);
            end
            req[REQ_DISP] = (c <= 4) || (c >= 6 && c <= 8);
        end
        req = '0;
        step();
        step();
        step();
    endtask

    task automatic test_reset_mid();
        set_req(REQ_PAR, 1'b1, 4'd7, 32'hA5A5_A5A5);
        step();
        n_tests++;
        if (regf_en !== 1'b1 || regf_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rstw_access: en=%b we=%b want 1 1", regf_en, regf_we);
        end
        rst = 1'b0;
        req = '0;
        step();
        n_tests++;
        if (gnt !== 3'b000 || busy !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rstw_abort: gnt=%b busy=%b rdata=%h want 000 0 0", gnt, busy, rdata);
        end
        rst = 1'b1;
        step();
        set_req(REQ_PS2, 1'b0, 4'd7, 32'h0);
        step();
        step();
        n_tests++;
        if (gnt !== 3'b010 || rdata !== 32'hA5A5_A5A5) begin
            n_fail++;
            $display("FAIL rstw_commit: gnt=%b rdata=%h want 010 a5a5a5a5", gnt, rdata);
        end
        step();
        req = '0;
        step();
        set_req(REQ_DISP, 1'b0, 4'd7, 32'h0);
        step();
        rst = 1'b0;
        req = '0;
        step();
        n_tests++;
        if (gnt !== 3'b000 || busy !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rstr_abort: gnt=%b busy=%b rdata=%h want 000 0 0", gnt, busy, rdata);
        end
        rst = 1'b1;
        step();
        n_tests++;
        if (gnt !== 3'b000 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rstr_after: gnt=%b rdata=%h want 000 0", gnt, rdata);
        end
    endtask

    task automatic test_idle();
        req = '0;
        for (int c = 0; c < 20; c++) begin
            step();
            n_tests++;
            if ({regf_en, busy, gnt} !== 5'b0) begin
                n_fail++;
                $display("FAIL idle_c%0d: en=%b busy=%b gnt=%b want 0 0 000", c, regf_en, busy, gnt);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        req     = '0;
        we      = '0;
        addr    = '0;
        wdata   = '0;
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_masking();
        test_reset_mid();
        test_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
